// File: rtl/pipeline_sched_pkg.sv
// Shared encodings for the pipeline scheduler: FSM states, stall/flush bit
// positions, sched types, the ERET interrupt id and the cause field layout.
package pipeline_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_STATE_RUN   = 2'd0,
    SCHED_STATE_DRAIN = 2'd1,
    SCHED_STATE_JUMP  = 2'd2
  } sched_state_t;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  localparam int FLUSH_PC     = 0;
  localparam int FLUSH_IF_ID  = 1;
  localparam int FLUSH_ID_EX  = 2;
  localparam int FLUSH_EX_MEM = 3;
  localparam int FLUSH_MEM_WB = 4;

  localparam logic [3:0] SCHED_CONTINUE     = 4'd0;
  localparam logic [3:0] SCHED_PAUSE_FOR_LW = 4'd1;

  localparam logic [3:0] INT_ID_ERET = 4'hF;

  localparam int CAUSE_ID_LSB  = 0;
  localparam int CAUSE_EXT_BIT = 4;

  function automatic logic [7:0] make_cause(input logic ext_flag, input logic [3:0] int_id);
    logic [7:0] c;
    c = 8'h00;
    c[CAUSE_EXT_BIT] = ext_flag;
    c[CAUSE_ID_LSB +: 4] = int_id;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sched_if.sv
// Bundle between the pipeline (master) and the scheduler (slave); schedo_state
// is a debug view of the scheduler FSM.
interface pipeline_sched_if;
  import pipeline_sched_pkg::*;

  logic         schedi_pause_request;
  logic [3:0]   schedi_sched_type;
  logic         schedi_mem_busy;
  logic         schedi_int;
  logic [3:0]   schedi_int_id;
  logic [15:0]  schedi_id_addr;
  logic         schedi_branch;
  logic         schedi_ext_int;
  logic [3:0]   schedi_ext_int_id;
  logic         schedi_int_enable;
  logic         schedi_int_disable;

  logic [4:0]   schedo_stall;
  logic [4:0]   schedo_flush;
  logic         schedo_pc_load;
  logic [15:0]  schedo_new_pc;
  logic [15:0]  schedo_epc;
  logic [7:0]   schedo_cause;
  logic         schedo_int_en;
  logic [3:0]   schedo_sched_count;
  sched_state_t schedo_state;

  modport master (
    output schedi_pause_request, schedi_sched_type, schedi_mem_busy, schedi_int,
           schedi_int_id, schedi_id_addr, schedi_branch, schedi_ext_int,
           schedi_ext_int_id, schedi_int_enable, schedi_int_disable,
    input  schedo_stall, schedo_flush, schedo_pc_load, schedo_new_pc, schedo_epc,
           schedo_cause, schedo_int_en, schedo_sched_count, schedo_state
  );

  modport slave (
    input  schedi_pause_request, schedi_sched_type, schedi_mem_busy, schedi_int,
           schedi_int_id, schedi_id_addr, schedi_branch, schedi_ext_int,
           schedi_ext_int_id, schedi_int_enable, schedi_int_disable,
    output schedo_stall, schedo_flush, schedo_pc_load, schedo_new_pc, schedo_epc,
           schedo_cause, schedo_int_en, schedo_sched_count, schedo_state
  );

endinterface

// File: rtl/pipeline_sched_int_latch.sv
// Holds one pending external interrupt and its source id until serviced.
// The first id wins; later pulses are dropped while one is pending.
module pipeline_sched_int_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_int,
  input  logic [3:0] ext_int_id,
  input  logic       clear,
  output logic       pending,
  output logic [3:0] pending_id
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending    <= 1'b0;
      pending_id <= 4'h0;
    end else if (ext_int && (!pending || clear)) begin
      // A pulse landing on the service cycle becomes the next pending request.
      pending    <= 1'b1;
      pending_id <= ext_int_id;
    end else if (clear) begin
      pending    <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_sched.sv
// Central stall/flush/redirect scheduler for the 5-stage CPU, including
// interrupt entry (drain then jump to the handler) and ERET.
module pipeline_sched
  import pipeline_sched_pkg::*;
#(
  parameter logic [15:0] HANDLER_ADDR = 16'h0008,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  pipeline_sched_if.slave sched
);

  sched_state_t state;
  logic [3:0]   counter;
  logic [15:0]  epc;
  logic [7:0]   cause;
  logic         int_en;
  logic         ext_pending;
  logic [3:0]   ext_id;

  logic [4:0]   stall;
  logic [4:0]   flush;
  logic         pc_load;
  logic [15:0]  new_pc;
  logic         take_sw;
  logic         take_eret;
  logic         take_ext;

  pipeline_sched_int_latch u_int_latch (
    .clk        (clk),
    .rst        (rst),
    .ext_int    (sched.schedi_ext_int),
    .ext_int_id (sched.schedi_ext_int_id),
    .clear      (take_ext),
    .pending    (ext_pending),
    .pending_id (ext_id)
  );

  always_comb begin
    stall     = 5'b0;
    flush     = 5'b0;
    pc_load   = 1'b0;
    new_pc    = 16'h0000;
    take_sw   = 1'b0;
    take_eret = 1'b0;
    take_ext  = 1'b0;
    case (state)
      SCHED_STATE_RUN: begin
        if (sched.schedi_mem_busy) begin
          stall[STALL_PC]    = 1'b1;
          flush[FLUSH_IF_ID] = 1'b1;
        end else if (sched.schedi_pause_request &&
                     sched.schedi_sched_type == SCHED_PAUSE_FOR_LW) begin
          stall[STALL_PC]    = 1'b1;
          stall[STALL_IF_ID] = 1'b1;
          flush[FLUSH_ID_EX] = 1'b1;
        end else if (sched.schedi_int && sched.schedi_int_id != INT_ID_ERET) begin
          flush[FLUSH_IF_ID] = 1'b1;
          take_sw            = 1'b1;
        end else if (sched.schedi_int) begin
          pc_load            = 1'b1;
          new_pc             = epc;
          flush[FLUSH_IF_ID] = 1'b1;
          take_eret          = 1'b1;
        end else if (ext_pending && int_en && !sched.schedi_branch) begin
          // Deferred while branching so EPC never points into a delay slot.
          flush[FLUSH_IF_ID] = 1'b1;
          flush[FLUSH_ID_EX] = 1'b1;
          take_ext           = 1'b1;
        end
      end
      SCHED_STATE_DRAIN: begin
        stall[STALL_PC]    = 1'b1;
        flush[FLUSH_IF_ID] = 1'b1;
      end
      SCHED_STATE_JUMP: begin
        pc_load            = 1'b1;
        new_pc             = HANDLER_ADDR;
        flush[FLUSH_IF_ID] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SCHED_STATE_RUN;
      counter <= 4'd0;
      epc     <= 16'h0000;
      cause   <= 8'h00;
      int_en  <= 1'b0;
    end else begin
      case (state)
        SCHED_STATE_RUN: begin
          if (take_sw) begin
            epc     <= 16'(sched.schedi_id_addr + 16'd1);
            cause   <= make_cause(1'b0, sched.schedi_int_id);
            int_en  <= 1'b0;
            counter <= 4'(DRAIN_CYCLES);
            state   <= SCHED_STATE_DRAIN;
          end else if (take_eret) begin
            int_en  <= 1'b1;
          end else if (take_ext) begin
            epc     <= sched.schedi_id_addr;
            cause   <= make_cause(1'b1, ext_id);
            int_en  <= 1'b0;
            counter <= 4'(DRAIN_CYCLES);
            state   <= SCHED_STATE_DRAIN;
          end else if (sched.schedi_int_disable) begin
            int_en  <= 1'b0;
          end else if (sched.schedi_int_enable) begin
            int_en  <= 1'b1;
          end
        end
        SCHED_STATE_DRAIN: begin
          // The memory stage still owns the bus: hold the drain count.
          if (!sched.schedi_mem_busy) begin
            counter <= counter - 4'd1;
            if (counter == 4'd1) state <= SCHED_STATE_JUMP;
          end
        end
        SCHED_STATE_JUMP: state <= SCHED_STATE_RUN;
        default:          state <= SCHED_STATE_RUN;
      endcase
    end
  end

  assign sched.schedo_stall       = stall;
  assign sched.schedo_flush       = flush;
  assign sched.schedo_pc_load     = pc_load;
  assign sched.schedo_new_pc      = new_pc;
  assign sched.schedo_epc         = epc;
  assign sched.schedo_cause       = cause;
  assign sched.schedo_int_en      = int_en;
  assign sched.schedo_sched_count = (state == SCHED_STATE_DRAIN) ? counter : 4'd0;
  assign sched.schedo_state       = state;

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed bench for pipeline_sched: hazards, software/external interrupt
// entry, drain timing, ERET and reset during drain.
module tb_pipeline_sched;
  import pipeline_sched_pkg::*;

  logic clk;
  logic rst;
  int   test_cnt;
  int   fail_cnt;

  pipeline_sched_if bus ();

  pipeline_sched #(
    .HANDLER_ADDR (16'h0008),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.schedi_pause_request = 1'b0;
    bus.schedi_sched_type    = SCHED_CONTINUE;
    bus.schedi_mem_busy      = 1'b0;
    bus.schedi_int           = 1'b0;
    bus.schedi_int_id        = 4'h0;
    bus.schedi_id_addr       = 16'h0000;
    bus.schedi_branch        = 1'b0;
    bus.schedi_ext_int       = 1'b0;
    bus.schedi_ext_int_id    = 4'h0;
    bus.schedi_int_enable    = 1'b0;
    bus.schedi_int_disable   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"},   32'(bus.schedo_stall),   32'h0);
    chk({tag, "_flush"},   32'(bus.schedo_flush),   32'h0);
    chk({tag, "_pc_load"}, 32'(bus.schedo_pc_load), 32'h0);
    chk({tag, "_new_pc"},  32'(bus.schedo_new_pc),  32'h0);
  endtask

  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();

    // reset state
    chk_idle("rst");
    chk("rst_epc",   32'(bus.schedo_epc),         32'h0);
    chk("rst_cause", 32'(bus.schedo_cause),       32'h0);
    chk("rst_int_en",32'(bus.schedo_int_en),      32'h0);
    chk("rst_count", 32'(bus.schedo_sched_count), 32'h0);
    chk("rst_state", 32'(bus.schedo_state),       32'(SCHED_STATE_RUN));
    rst = 1'b1;
    tick();

    // load-use pause, one cycle
    bus.schedi_pause_request = 1'b1;
    bus.schedi_sched_type    = SCHED_PAUSE_FOR_LW;
    #1;
    chk("lw_stall", 32'(bus.schedo_stall), 32'h03);
    chk("lw_flush", 32'(bus.schedo_flush), 32'h04);
    tick();
    clear_inputs();
    #1;
    chk_idle("lw_after");

    // pause with SCHED_CONTINUE is not a hazard
    bus.schedi_pause_request = 1'b1;
    bus.schedi_sched_type    = SCHED_CONTINUE;
    #1;
    chk("cont_stall", 32'(bus.schedo_stall), 32'h0);
    tick();

    // mem_busy beats pause
    bus.schedi_mem_busy      = 1'b1;
    bus.schedi_pause_request = 1'b1;
    bus.schedi_sched_type    = SCHED_PAUSE_FOR_LW;
    #1;
    chk("mb_stall", 32'(bus.schedo_stall), 32'h01);
    chk("mb_flush", 32'(bus.schedo_flush), 32'h02);
    tick();
    clear_inputs();

    // MTIH enable, then enable+disable together
    bus.schedi_int_enable = 1'b1;
    tick();
    chk("mtih_en", 32'(bus.schedo_int_en), 32'h1);
    bus.schedi_int_disable = 1'b1;
    tick();
    chk("mtih_both", 32'(bus.schedo_int_en), 32'h0);
    bus.schedi_int_disable = 1'b0;
    tick();
    chk("mtih_en2", 32'(bus.schedo_int_en), 32'h1);
    clear_inputs();

    // software INT 3 at 0x0040
    bus.schedi_int     = 1'b1;
    bus.schedi_int_id  = 4'h3;
    bus.schedi_id_addr = 16'h0040;
    #1;
    chk("sw_flush", 32'(bus.schedo_flush), 32'h02);
    chk("sw_stall", 32'(bus.schedo_stall), 32'h00);
    tick();
    clear_inputs();
    bus.schedi_pause_request = 1'b1;
    bus.schedi_sched_type    = SCHED_PAUSE_FOR_LW;
    #1;
    chk("sw_epc",    32'(bus.schedo_epc),         32'h0041);
    chk("sw_cause",  32'(bus.schedo_cause),       32'h03);
    chk("sw_int_en", 32'(bus.schedo_int_en),      32'h0);
    chk("sw_state",  32'(bus.schedo_state),       32'(SCHED_STATE_DRAIN));
    chk("dr_cnt2",   32'(bus.schedo_sched_count), 32'h2);
    chk("dr_stall",  32'(bus.schedo_stall),       32'h01);
    chk("dr_flush",  32'(bus.schedo_flush),       32'h02);
    tick();
    clear_inputs();
    chk("dr_cnt1",   32'(bus.schedo_sched_count), 32'h1);
    bus.schedi_mem_busy = 1'b1;
    tick();
    bus.schedi_mem_busy = 1'b0;
    chk("dr_hold",   32'(bus.schedo_sched_count), 32'h1);
    chk("dr_hold_st",32'(bus.schedo_state),       32'(SCHED_STATE_DRAIN));
    tick();
    chk("jmp_state", 32'(bus.schedo_state),       32'(SCHED_STATE_JUMP));
    chk("jmp_load",  32'(bus.schedo_pc_load),     32'h1);
    chk("jmp_pc",    32'(bus.schedo_new_pc),      32'h0008);
    chk("jmp_flush", 32'(bus.schedo_flush),       32'h02);
    chk("jmp_cnt",   32'(bus.schedo_sched_count), 32'h0);
    tick();
    chk("post_jmp",  32'(bus.schedo_state),       32'(SCHED_STATE_RUN));
    chk_idle("post_jmp");

    // ERET
    bus.schedi_int    = 1'b1;
    bus.schedi_int_id = INT_ID_ERET;
    #1;
    chk("eret_load",  32'(bus.schedo_pc_load), 32'h1);
    chk("eret_pc",    32'(bus.schedo_new_pc),  32'h0041);
    chk("eret_flush", 32'(bus.schedo_flush),   32'h02);
    tick();
    clear_inputs();
    chk("eret_int_en",32'(bus.schedo_int_en),  32'h1);

    // external id 5 deferred by a branch
    bus.schedi_ext_int    = 1'b1;
    bus.schedi_ext_int_id = 4'h5;
    bus.schedi_branch     = 1'b1;
    bus.schedi_id_addr    = 16'h00F0;
    #1;
    chk("ext_pulse_flush", 32'(bus.schedo_flush), 32'h0);
    tick();
    bus.schedi_ext_int = 1'b0;
    chk("ext_defer_flush", 32'(bus.schedo_flush), 32'h0);
    chk("ext_defer_state", 32'(bus.schedo_state), 32'(SCHED_STATE_RUN));
    tick();
    bus.schedi_branch  = 1'b0;
    bus.schedi_id_addr = 16'h0100;
    #1;
    chk("ext_flush", 32'(bus.schedo_flush), 32'h06);
    chk("ext_stall", 32'(bus.schedo_stall), 32'h00);
    tick();
    clear_inputs();
    chk("ext_epc",    32'(bus.schedo_epc),    32'h0100);
    chk("ext_cause",  32'(bus.schedo_cause),  32'h15);
    chk("ext_int_en", 32'(bus.schedo_int_en), 32'h0);
    chk("ext_state",  32'(bus.schedo_state),  32'(SCHED_STATE_DRAIN));

    // reset during DRAIN
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_state", 32'(bus.schedo_state),       32'(SCHED_STATE_RUN));
    chk_idle("mid_rst");
    chk("mid_rst_epc",   32'(bus.schedo_epc),         32'h0);
    chk("mid_rst_cause", 32'(bus.schedo_cause),       32'h0);
    chk("mid_rst_cnt",   32'(bus.schedo_sched_count), 32'h0);
    tick();
    chk("mid_rst_nojmp", 32'(bus.schedo_pc_load),     32'h0);

    // software INT beats a pending external request
    bus.schedi_int_enable = 1'b1;
    tick();
    bus.schedi_int_enable = 1'b0;
    bus.schedi_ext_int    = 1'b1;
    bus.schedi_ext_int_id = 4'h7;
    bus.schedi_branch     = 1'b1;
    tick();
    clear_inputs();
    bus.schedi_int     = 1'b1;
    bus.schedi_int_id  = 4'h2;
    bus.schedi_id_addr = 16'h0200;
    #1;
    chk("both_flush", 32'(bus.schedo_flush), 32'h02);
    tick();
    clear_inputs();
    chk("both_cause", 32'(bus.schedo_cause), 32'h02);
    chk("both_epc",   32'(bus.schedo_epc),   32'h0201);
    bus.schedi_ext_int    = 1'b1;
    bus.schedi_ext_int_id = 4'h9;
    tick();
    clear_inputs();
    tick();
    tick();
    chk("both_run", 32'(bus.schedo_state), 32'(SCHED_STATE_RUN));
    chk("blocked_flush", 32'(bus.schedo_flush), 32'h0);
    bus.schedi_int    = 1'b1;
    bus.schedi_int_id = INT_ID_ERET;
    #1;
    chk("eret2_pc", 32'(bus.schedo_new_pc), 32'h0201);
    tick();
    clear_inputs();
    bus.schedi_id_addr = 16'h0300;
    #1;
    chk("pend_flush", 32'(bus.schedo_flush), 32'h06);
    tick();
    clear_inputs();
    chk("pend_cause", 32'(bus.schedo_cause), 32'h17);
    chk("pend_epc",   32'(bus.schedo_epc),   32'h0300);

    // final report
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
